// File: rtl/aes_byte_loader.sv
// Byte-serial front end for the mainAES core: gathers 16 plaintext and 16 key
// bytes, waits a fixed latency for the core, then streams the ciphertext back out.
module aes_byte_loader #(
  parameter int unsigned WAIT_CYCLES = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] aes_input,
  output logic [127:0] aes_key,
  output logic         aes_start,
  input  logic [127:0] aes_output,
  output logic         out_valid,
  output logic [7:0]   out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  // state      | meaning
  // IDLE       | one-cycle gap between transactions
  // LOAD_DATA  | shifting in plaintext bytes
  // LOAD_KEY   | shifting in key bytes
  // WAIT       | core computing; operands held stable
  // SEND       | streaming ciphertext bytes out
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_DATA = 3'd1;
  localparam logic [2:0] ST_LOAD_KEY  = 3'd2;
  localparam logic [2:0] ST_WAIT      = 3'd3;
  localparam logic [2:0] ST_SEND      = 3'd4;

  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

  logic [2:0]   state;
  logic [3:0]   byte_cnt;
  logic [7:0]   wait_cnt;
  logic [127:0] result;
  logic         in_acc;
  logic         out_acc;

  assign in_ready  = (state == ST_LOAD_DATA) || (state == ST_LOAD_KEY);
  assign out_valid = (state == ST_SEND);
  assign out_last  = out_valid && (byte_cnt == 4'd15);
  assign out_data  = result[127:120];
  assign busy      = (state != ST_IDLE);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= 4'd0;
      wait_cnt  <= 8'd0;
      aes_input <= 128'h0;
      aes_key   <= 128'h0;
      result    <= 128'h0;
      aes_start <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_LOAD_DATA;
        end
        ST_LOAD_DATA: begin
          if (in_acc) begin
            aes_input <= {aes_input[119:0], in_data};
            byte_cnt  <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) state <= ST_LOAD_KEY;
          end
        end
        ST_LOAD_KEY: begin
          if (in_acc) begin
            aes_key  <= {aes_key[119:0], in_data};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              state     <= ST_WAIT;
              wait_cnt  <= WAIT_LOAD;
              aes_start <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // Capture in the last WAIT cycle so WAIT lasts exactly WAIT_CYCLES cycles.
          if (wait_cnt == 8'd0) begin
            result <= aes_output;
            state  <= ST_SEND;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ST_SEND: begin
          if (out_acc) begin
            result   <= {result[119:0], 8'h00};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          byte_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Scoreboard bench for aes_byte_loader: stimulus pushes expected operands and
// ciphertext bytes; a negedge monitor pops and compares as the DUT presents them.
module tb_aes_byte_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic [127:0] aes_input;
  logic [127:0] aes_key;
  logic         aes_start;
  logic [127:0] aes_output = 128'h0;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic         busy;

  aes_byte_loader #(.WAIT_CYCLES(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .aes_input  (aes_input),
    .aes_key    (aes_key),
    .aes_start  (aes_start),
    .aes_output (aes_output),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endfunction

  logic [255:0] exp_regs[$];
  logic [8:0]   exp_bytes[$];
  int           last_accept_cyc = 0;
  bit           stall_en = 1'b0;
  int           stall_cnt = 0;

  // Downstream stall generator: holds out_ready low for 7 cycles on byte 8'h33.
  always @(posedge clk) begin
    #1;
    if (stall_en && out_valid && out_data == 8'h33 && stall_cnt < 7) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor
  bit           prev_start = 0, prev_hold = 0, prev_last = 0, prev_acc_nonlast = 0;
  logic [7:0]   prev_data = 8'h00;
  bit           win = 0, stab = 0, after_last = 0;
  int           idle_cnt = 0, byte_idx = 0;
  logic [127:0] cap_in, cap_key;
  logic [255:0] e_regs;
  logic [8:0]   e_byte;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_start) chk("aes_start_single_pulse", aes_start, 0);
      prev_start = aes_start;

      if (aes_start) begin
        if (exp_regs.size() == 0) chk("unexpected_aes_start", 1, 0);
        else begin
          e_regs = exp_regs.pop_front();
          chk("aes_input", aes_input, e_regs[255:128]);
          chk("aes_key", aes_key, e_regs[127:0]);
        end
        win = 1; stab = 1; cap_in = aes_input; cap_key = aes_key;
      end else if (stab) begin
        chk("operands_stable", {aes_input, aes_key}, {cap_in, cap_key});
        if (in_valid && in_ready) stab = 0;
      end

      if (win) chk("in_ready_low_wait_send", in_ready, 0);

      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (prev_acc_nonlast) chk("stream_consecutive", out_valid, 1);

      if (after_last) begin
        if (idle_cnt == 0) chk("valid_low_after_last", out_valid, 0);
        if (busy) begin
          chk("idle_cycles", idle_cnt, 1);
          after_last = 0;
        end else idle_cnt++;
      end

      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      prev_acc_nonlast = 0;
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) chk("unexpected_out_byte", 1, 0);
        else begin
          e_byte = exp_bytes.pop_front();
          chk("out_data", out_data, e_byte[7:0]);
          chk("out_last", out_last, e_byte[8]);
          if (byte_idx == 0) chk("first_byte_latency", cyc - last_accept_cyc, 13);
        end
        byte_idx = (byte_idx + 1) % 16;
        if (out_last) begin
          win = 0; after_last = 1; idle_cnt = 0;
        end else prev_acc_nonlast = 1;
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_last);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    if (is_last) last_accept_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] ct, input int max_gap);
    logic [7:0] b;
    exp_regs.push_back({pt, key});
    for (int i = 0; i < 16; i++) exp_bytes.push_back({(i == 15), ct[127-8*i -: 8]});
    for (int i = 0; i < 32; i++) begin
      b = (i < 16) ? pt[127-8*i -: 8] : key[127-8*(i-16) -: 8];
      send_byte(b, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, (i == 31));
      // Previous transaction has been captured once this byte is accepted.
      if (i == 0) aes_output = ct;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_bytes.size() != 0 && n < 400) begin @(posedge clk); n++; end
    chk("drain_timeout", exp_bytes.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_aes_start"}, aes_start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_aes_input"}, aes_input, 0);
    chk({tag, "_aes_key"}, aes_key, 0);
  endtask

  localparam logic [127:0] V   = 128'h0123456789ABCDEF0123456789000000;
  localparam logic [127:0] CT1 = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    #3;
    check_reset_outputs("reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(V, V, CT1, 0);
    drain();

    run_txn(V, V, 128'hFFEEDDCCBBAA99887766554433221100, 5);
    drain();

    stall_cnt = 0;
    stall_en  = 1'b1;
    run_txn(128'h3243F6A8885A308D313198A2E0370734, 128'h2B7E151628AED2A6ABF7158809CF4F3C, CT1, 0);
    drain();
    chk("stall_cycles", stall_cnt, 7);
    stall_en = 1'b0;

    // Abort after 20 bytes; reset must act without a clock edge.
    for (int i = 0; i < 20; i++) send_byte(8'hA5, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(128'h000102030405060708090A0B0C0D0E0F, 128'h101112131415161718191A1B1C1D1E1F,
            128'h69C4E0D86A7B0430D8CDB78070B4C55A, 0);
    run_txn(128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0,
            128'hDEADBEEFCAFEF00D0123456789ABCDEF, 2);
    drain();
    chk("regs_queue_empty", exp_regs.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_byte_loader.md
AES_BYTE_LOADER -- requirements
Module: aes_byte_loader

Interface
REQ-001 Parameter WAIT_CYCLES, default 12: the number of clk cycles that aes_input and aes_key are held stable before aes_output is sampled; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset; assertion acts immediately, deassertion is taken synchronously to clk.
REQ-004 in_valid  in  1  the upstream byte on in_data is valid.
REQ-005 in_data  in  8  upstream byte: 16 plaintext bytes followed by 16 key bytes, most significant byte first.
REQ-006 in_ready  out  1  the loader accepts a byte this cycle.
REQ-007 aes_input  out  128  plaintext to the mainAES aes_input port.
REQ-008 aes_key  out  128  key to the mainAES aes_key port.
REQ-009 aes_start  out  1  one-cycle pulse marking that aes_input and aes_key are now valid.
REQ-010 aes_output  in  128  ciphertext from the mainAES aes_output port.
REQ-011 out_valid  out  1  out_data holds a valid ciphertext byte.
REQ-012 out_data  out  8  ciphertext byte, most significant byte first.
REQ-013 out_last  out  1  high together with out_valid on the 16th ciphertext byte.
REQ-014 out_ready  in  1  downstream accepts the byte this cycle.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, LOAD_DATA, LOAD_KEY, WAIT and SEND.
REQ-017 IDLE SHALL go to LOAD_DATA on the next clk edge unconditionally, with in_ready low while in IDLE.
REQ-018 in_ready SHALL be high only in LOAD_DATA and LOAD_KEY; a byte is accepted when in_valid and in_ready are both high.
REQ-019 Each accepted byte SHALL shift into the current target register: target = {target[119:0], in_data}, so that byte 0 ends in bits [127:120].
REQ-020 A 4-bit byte counter SHALL increment on each accepted byte and wrap 15->0; an accept when the count is 15 SHALL move LOAD_DATA->LOAD_KEY or LOAD_KEY->WAIT.
REQ-021 Cycles with in_valid low SHALL leave the registers and the counter unchanged, so input gaps of any length are tolerated.
REQ-022 aes_start SHALL pulse high for exactly the first cycle in WAIT.
REQ-023 aes_input and aes_key SHALL not change from WAIT entry until the next LOAD_DATA accept.
REQ-024 A wait counter SHALL be loaded with WAIT_CYCLES-1 on WAIT entry and decrement each cycle.
REQ-025 In the WAIT cycle where the wait counter is 0, aes_output SHALL be captured into a 128-bit result register and the state SHALL go to SEND.
REQ-026 The first ciphertext byte is therefore valid WAIT_CYCLES+1 cycles after the 32nd accept.
REQ-027 In SEND, out_valid SHALL be high and out_data SHALL equal result[127:120].
REQ-028 On out_valid and out_ready both high, the result register SHALL shift left by 8 and the byte counter SHALL increment.
REQ-029 While out_ready is low, out_data, out_last and out_valid SHALL hold their values indefinitely.
REQ-030 out_last SHALL be high exactly when the state is SEND and the byte count is 15.
REQ-031 The accepted transfer of the last byte SHALL go to IDLE with the counter at 0 and out_valid low on the next cycle.
REQ-032 in_valid during WAIT or SEND SHALL be ignored (in_ready is low); out_ready outside SEND SHALL be ignored.

Reset
REQ-033 While rst_n is low: state=IDLE; counters=0; aes_input, aes_key and the result register = 128'h0; in_ready, aes_start, out_valid, out_last and busy = 0; out_data = 8'h00.
REQ-034 Reset asserted mid-operation SHALL abort the transaction immediately and discard any partial bytes.
REQ-035 The first byte accepted after reset SHALL be treated as plaintext byte 0.

Verification
REQ-036 Stream 32 back-to-back bytes, plaintext and key both 128'h0123456789ABCDEF0123456789000000 -> aes_input and aes_key equal that value at WAIT entry, and aes_start pulses once.
REQ-037 With WAIT_CYCLES=12, drive aes_output=128'h00112233445566778899AABBCCDDEEFF and hold out_ready high -> bytes 00,11,...,FF arrive on 16 consecutive cycles starting 13 cycles after the 32nd accept, with out_last only on FF.
REQ-038 Insert random in_valid gaps (up to 5 cycles) -> registers identical to REQ-036; in_ready low throughout WAIT and SEND.
REQ-039 Hold out_ready low for 7 cycles on byte 3 -> out_data stays 33 and out_valid stays high; streaming resumes with no byte lost or duplicated.
REQ-040 Pull rst_n low after 20 accepted bytes -> all outputs reach their reset values without waiting for a clock edge; a fresh 32-byte load then produces the correct aes_input and aes_key.
REQ-041 Run two transactions back to back -> IDLE lasts 1 cycle between them, and the second transaction's aes_input does not change before its first accept.
